wb_port_arbiter: RTL and testbench

//  Shares the register file's single write port (WB_EN/DEST_WB/RESULT_WB) between two writeback requesters.

---
 rtl/wb_port_arbiter_pkg.sv | 17 +
 rtl/wb_port_arbiter_starve_counter.sv | 44 ++++
 rtl/wb_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file writeback port arbiter.
//   arb_state_e : arbiter priority state (ST_P0 = WB stage first, ST_P1 = multi-cycle unit first)
//   GRANT_REQ0/GRANT_REQ1 : encodings driven on grant_id
//   CNT_W : width of the req1 starvation counter
package wb_arb_defs;

   typedef enum logic {
      ST_P0 = 1'b0,
      ST_P1 = 1'b1
   } arb_state_e;

   localparam logic GRANT_REQ0 = 1'b0;
   localparam logic GRANT_REQ1 = 1'b1;

   localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/wb_port_arbiter_starve_counter.sv
// Saturating starvation counter for the multi-cycle writeback requester.
//   clk, rst          : clock, asynchronous active-high reset
//   i_inc             : requester lost arbitration this cycle
//   i_clr             : requester was granted this cycle (takes precedence)
//   o_limit_next_c    : count becomes LIMIT at the coming edge
module wb_starve_counter
   import wb_arb_defs::*;
#(
   parameter int unsigned LIMIT = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_limit_next_c
);

   localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_next;

   // Next count: clear wins, otherwise increment until saturated at LIM.
   always_comb begin
      w_count_next = r_count;
      if (i_clr) begin
         w_count_next = '0;
      end else if (i_inc && (r_count != LIM)) begin
         w_count_next = r_count + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_next;
      end
   end

   // Looks at the next value so the priority flip lands on the very next cycle.
   assign o_limit_next_c = (w_count_next == LIM) && !i_clr;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register file's single write port between the WB stage (req0)
// and a multi-cycle unit (req1), and tracks outstanding writes per register.
//   clk, rst                       : clock, asynchronous active-high reset
//   req0_valid/dest/data, req0_ready : WB-stage request, combinational accept
//   req1_valid/dest/data, req1_ready : multi-cycle request, combinational accept
//   claim_en, claim_dest           : issue stage marks a register as awaiting writeback
//   WB_EN, DEST_WB, RESULT_WB      : registered register-file write port
//   grant_id                       : source of the current write (registered)
//   pending                        : per-register outstanding-write scoreboard (registered)
module wb_port_arbiter
   import wb_arb_defs::*;
#(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned ADDR_W       = 4,
   parameter int unsigned NUM_REGS     = 16,
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req0_valid,
   input  logic [ADDR_W-1:0]   req0_dest,
   input  logic [DATA_W-1:0]   req0_data,
   output logic                req0_ready,
   input  logic                req1_valid,
   input  logic [ADDR_W-1:0]   req1_dest,
   input  logic [DATA_W-1:0]   req1_data,
   output logic                req1_ready,
   input  logic                claim_en,
   input  logic [ADDR_W-1:0]   claim_dest,
   output logic                WB_EN,
   output logic [ADDR_W-1:0]   DEST_WB,
   output logic [DATA_W-1:0]   RESULT_WB,
   output logic                grant_id,
   output logic [NUM_REGS-1:0] pending
);

   arb_state_e          r_state;
   arb_state_e          w_state_next;
   logic                w_gnt0;
   logic                w_gnt1;
   logic                w_limit_hit;
   logic [NUM_REGS-1:0] w_set_mask;
   logic [NUM_REGS-1:0] w_clr_mask;
   logic [NUM_REGS-1:0] w_pending_next;

   // Starvation tracking for req1: counts cycles it waits while valid.
   wb_starve_counter #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk            (clk),
      .rst            (rst),
      .i_inc          (req1_valid && !w_gnt1),
      .i_clr          (w_gnt1),
      .o_limit_next_c (w_limit_hit)
   );

   // Priority state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_P0;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Grant select and next state; no grant is issued while reset is held.
   always_comb begin
      w_gnt0       = 1'b0;
      w_gnt1       = 1'b0;
      w_state_next = r_state;
      if (!rst) begin
         case (r_state)
            ST_P0: begin
               if (req0_valid) begin
                  w_gnt0 = 1'b1;
               end else if (req1_valid) begin
                  w_gnt1 = 1'b1;
               end
               if (w_limit_hit) begin
                  w_state_next = ST_P1;
               end
            end
            ST_P1: begin
               // Exactly one forced req1 grant, then back to normal priority.
               if (req1_valid) begin
                  w_gnt1       = 1'b1;
                  w_state_next = ST_P0;
               end else if (req0_valid) begin
                  w_gnt0 = 1'b1;
               end
            end
            default: begin
               w_state_next = ST_P0;
            end
         endcase
      end
   end

   assign req0_ready = w_gnt0;
   assign req1_ready = w_gnt1;

   // Write-port register: one cycle after accept the register file sees the write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         WB_EN     <= 1'b0;
         DEST_WB   <= '0;
         RESULT_WB <= '0;
         grant_id  <= GRANT_REQ0;
      end else begin
         WB_EN <= w_gnt0 | w_gnt1;
         if (w_gnt1) begin
            DEST_WB   <= req1_dest;
            RESULT_WB <= req1_data;
            grant_id  <= GRANT_REQ1;
         end else if (w_gnt0) begin
            DEST_WB   <= req0_dest;
            RESULT_WB <= req0_data;
            grant_id  <= GRANT_REQ0;
         end
      end
   end

   // Scoreboard: a claim in the same cycle as a clear wins, since it is newer.
   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      if (claim_en) begin
         w_set_mask = NUM_REGS'(1) << claim_dest;
      end
      if (w_gnt1) begin
         w_clr_mask = NUM_REGS'(1) << req1_dest;
      end else if (w_gnt0) begin
         w_clr_mask = NUM_REGS'(1) << req0_dest;
      end
      w_pending_next = (pending & ~w_clr_mask) | w_set_mask;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
      end else begin
         pending <= w_pending_next;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected writes are queued when a request
// is driven with an expected accept and popped when the write port shows it.
module tb_wb_port_arbiter;

   typedef struct packed {
      logic        gid;
      logic [3:0]  dest;
      logic [31:0] data;
   } wb_exp_t;

   logic        clk;
   logic        rst;
   logic        req0_valid;
   logic [3:0]  req0_dest;
   logic [31:0] req0_data;
   logic        req0_ready;
   logic        req1_valid;
   logic [3:0]  req1_dest;
   logic [31:0] req1_data;
   logic        req1_ready;
   logic        claim_en;
   logic [3:0]  claim_dest;
   logic        WB_EN;
   logic [3:0]  DEST_WB;
   logic [31:0] RESULT_WB;
   logic        grant_id;
   logic [15:0] pending;

   int          n_assert;
   int          n_fail;
   wb_exp_t     q[$];
   logic [15:0] exp_pend;
   logic [31:0] rf [16];

   wb_port_arbiter #(
      .DATA_W       (32),
      .ADDR_W       (4),
      .NUM_REGS     (16),
      .STARVE_LIMIT (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_dest  (req0_dest),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_dest  (req1_dest),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .claim_en   (claim_en),
      .claim_dest (claim_dest),
      .WB_EN      (WB_EN),
      .DEST_WB    (DEST_WB),
      .RESULT_WB  (RESULT_WB),
      .grant_id   (grant_id),
      .pending    (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model: captures the write on the falling edge.
   always @(negedge clk) begin
      if (WB_EN === 1'b1) begin
         rf[DEST_WB] <= RESULT_WB;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_assert++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   // One clock of stimulus: drive, check accepts, queue expectations, then check the write port.
   task automatic cycle(input logic v0, input logic [3:0] d0, input logic [31:0] x0,
                        input logic v1, input logic [3:0] d1, input logic [31:0] x1,
                        input logic ce, input logic [3:0] cd,
                        input logic er0, input logic er1);
      wb_exp_t     e;
      logic [15:0] clr;
      logic [15:0] set;
      req0_valid = v0; req0_dest = d0; req0_data = x0;
      req1_valid = v1; req1_dest = d1; req1_data = x1;
      claim_en   = ce; claim_dest = cd;
      #1;
      chk("req0_ready", 64'(req0_ready), 64'(er0));
      chk("req1_ready", 64'(req1_ready), 64'(er1));
      clr = 16'h0;
      set = ce ? (16'(1) << cd) : 16'h0;
      if (er0) begin
         q.push_back({1'b0, d0, x0});
         clr = 16'(1) << d0;
      end
      if (er1) begin
         q.push_back({1'b1, d1, x1});
         clr = 16'(1) << d1;
      end
      exp_pend = (exp_pend & ~clr) | set;
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
         e = q.pop_front();
         chk("WB_EN", 64'(WB_EN), 64'(1'b1));
         chk("DEST_WB", 64'(DEST_WB), 64'(e.dest));
         chk("RESULT_WB", 64'(RESULT_WB), 64'(e.data));
         chk("grant_id", 64'(grant_id), 64'(e.gid));
      end else begin
         chk("WB_EN idle", 64'(WB_EN), 64'(1'b0));
      end
      chk("pending", 64'(pending), 64'(exp_pend));
   endtask

   task automatic idle();
      cycle(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   initial begin
      logic        g1;
      logic [31:0] d1v;
      n_assert = 0;
      n_fail   = 0;
      exp_pend = 16'h0;
      for (int i = 0; i < 16; i++) rf[i] = 32'h0;
      rst = 1'b1;
      req0_valid = 1'b0; req0_dest = 4'd0; req0_data = 32'h0;
      req1_valid = 1'b0; req1_dest = 4'd0; req1_data = 32'h0;
      claim_en   = 1'b0; claim_dest = 4'd0;

      // Reset values.
      #2;
      chk("rst WB_EN", 64'(WB_EN), 64'(1'b0));
      chk("rst DEST_WB", 64'(DEST_WB), 64'(4'd0));
      chk("rst RESULT_WB", 64'(RESULT_WB), 64'(32'h0));
      chk("rst grant_id", 64'(grant_id), 64'(1'b0));
      chk("rst pending", 64'(pending), 64'(16'h0));
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset mid-write drops the write and clears the scoreboard.
      cycle(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd4, 1'b0, 1'b0);
      cycle(1'b1, 4'd3, 32'h1234_5678, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);
      rst = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk("midrst WB_EN", 64'(WB_EN), 64'(1'b0));
      chk("midrst pending", 64'(pending), 64'(16'h0));
      chk("midrst req0_ready", 64'(req0_ready), 64'(1'b0));
      chk("midrst req1_ready", 64'(req1_ready), 64'(1'b0));
      @(negedge clk);
      #1;
      chk("midrst R3 dropped", 64'(rf[3]), 64'(32'h0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_pend = 16'h0;

      // Single req0 write.
      cycle(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0);
      idle();
      chk("R3", 64'(rf[3]), 64'(32'hDEAD_BEEF));

      // Contention: req1 forced in after three losses.
      for (int i = 0; i < 5; i++) begin
         g1  = (i == 3);
         d1v = (i < 4) ? 32'hB000_0000 : 32'hB000_0001;
         cycle(1'b1, 4'd1, 32'hA000_0000 + 32'(i), 1'b1, 4'd8, d1v,
               1'b0, 4'd0, !g1, g1);
      end
      cycle(1'b0, 4'd0, 32'h0, 1'b1, 4'd8, 32'hB000_0001, 1'b0, 4'd0, 1'b0, 1'b1);
      idle();
      chk("R8", 64'(rf[8]), 64'(32'hB000_0001));

      // Claim R5, then req1 writes R5 two cycles later.
      cycle(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 1'b0, 1'b0);
      idle();
      cycle(1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 32'h0000_0055, 1'b0, 4'd0, 1'b0, 1'b1);

      // Claim R7 in the same cycle req0 writes R7.
      cycle(1'b1, 4'd7, 32'h0000_0077, 1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 1'b1, 1'b0);
      idle();

      // Same destination from both requesters: last write wins.
      cycle(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd2, 1'b0, 1'b0);
      cycle(1'b1, 4'd2, 32'h1, 1'b1, 4'd2, 32'h2, 1'b0, 4'd0, 1'b1, 1'b0);
      cycle(1'b0, 4'd0, 32'h0, 1'b1, 4'd2, 32'h2, 1'b0, 4'd0, 1'b0, 1'b1);
      chk("R2 first", 64'(rf[2]), 64'(32'h1));
      idle();
      chk("R2 last", 64'(rf[2]), 64'(32'h2));
      chk("pending[2]", 64'(pending[2]), 64'(1'b0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
